// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter.
// One transaction owns the slave from grant until its final R/B handshake.
module ysyx_25020037_axi_arbiter #(
    parameter bit LSU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // IFU read master
    input  logic        ifu_arvalid,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_arready,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,
    input  logic        ifu_rready,
    // LSU read/write master
    input  logic        lsu_arvalid,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_arready,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,
    input  logic        lsu_rready,
    input  logic        lsu_awvalid,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    output logic        lsu_awready,
    input  logic        lsu_wvalid,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_wready,
    output logic        lsu_bvalid,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,
    input  logic        lsu_bready,
    // Slave port
    output logic        s_awvalid,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    input  logic        s_awready,
    output logic        s_wvalid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_wready,
    input  logic        s_bvalid,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid,
    output logic        s_bready,
    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_rready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_IFU = 2'd1;
    localparam logic [1:0] RD_LSU = 2'd2;
    localparam logic [1:0] WR_LSU = 2'd3;

    logic [1:0] state_q, state_d;
    logic       rd_ifu, rd_lsu, wr_lsu;
    logic       lsu_req;
    logic [1:0] lsu_next;

    assign rd_ifu   = (state_q == RD_IFU);
    assign rd_lsu   = (state_q == RD_LSU);
    assign wr_lsu   = (state_q == WR_LSU);
    assign lsu_req  = lsu_arvalid | lsu_awvalid;
    // Reads beat writes inside the LSU.
    assign lsu_next = lsu_arvalid ? RD_LSU : WR_LSU;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (LSU_FIRST) begin
                    if (lsu_req)          state_d = lsu_next;
                    else if (ifu_arvalid) state_d = RD_IFU;
                end else begin
                    if (ifu_arvalid)      state_d = RD_IFU;
                    else if (lsu_req)     state_d = lsu_next;
                end
            end
            RD_IFU, RD_LSU: if (s_rvalid & s_rready & s_rlast) state_d = IDLE;
            WR_LSU:         if (s_bvalid & s_bready)           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0;
        ifu_rresp   = '0;   ifu_rlast  = 1'b0; ifu_rid   = '0;
        lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0;
        lsu_rresp   = '0;   lsu_rlast  = 1'b0; lsu_rid   = '0;
        lsu_awready = 1'b0; lsu_wready = 1'b0;
        lsu_bvalid  = 1'b0; lsu_bresp  = '0;   lsu_bid   = '0;
        s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0;
        s_awlen   = '0;   s_awsize = '0; s_awburst = '0;
        s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb = '0; s_wlast = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0;
        s_arlen   = '0;   s_arsize = '0; s_arburst = '0;
        s_rready  = 1'b0;
        unique case (1'b1)
            rd_ifu: begin
                s_arvalid   = ifu_arvalid; s_araddr = ifu_araddr;
                s_arid      = ifu_arid;    s_arlen  = ifu_arlen;
                s_arsize    = ifu_arsize;  s_arburst = ifu_arburst;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;    ifu_rdata = s_rdata;
                ifu_rresp   = s_rresp;     ifu_rlast = s_rlast;
                ifu_rid     = s_rid;       s_rready  = ifu_rready;
            end
            rd_lsu: begin
                s_arvalid   = lsu_arvalid; s_araddr = lsu_araddr;
                s_arid      = lsu_arid;    s_arlen  = lsu_arlen;
                s_arsize    = lsu_arsize;  s_arburst = lsu_arburst;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;    lsu_rdata = s_rdata;
                lsu_rresp   = s_rresp;     lsu_rlast = s_rlast;
                lsu_rid     = s_rid;       s_rready  = lsu_rready;
            end
            wr_lsu: begin
                s_awvalid   = lsu_awvalid; s_awaddr = lsu_awaddr;
                s_awid      = lsu_awid;    s_awlen  = lsu_awlen;
                s_awsize    = lsu_awsize;  s_awburst = lsu_awburst;
                lsu_awready = s_awready;
                s_wvalid    = lsu_wvalid;  s_wdata  = lsu_wdata;
                s_wstrb     = lsu_wstrb;   s_wlast  = lsu_wlast;
                lsu_wready  = s_wready;
                lsu_bvalid  = s_bvalid;    lsu_bresp = s_bresp;
                lsu_bid     = s_bid;       s_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed bench for the AXI arbiter; slave responses feed a scoreboard
// that is drained as the data appears on the granted master port.
module tb_ysyx_25020037_axi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ifu_arvalid = 0; logic [31:0] ifu_araddr = 0;
    logic [3:0]  ifu_arid = 0;    logic [7:0]  ifu_arlen = 0;
    logic [2:0]  ifu_arsize = 2;  logic [1:0]  ifu_arburst = 1;
    logic        ifu_arready, ifu_rvalid, ifu_rlast;
    logic [31:0] ifu_rdata;       logic [1:0]  ifu_rresp;
    logic [3:0]  ifu_rid;         logic        ifu_rready = 0;

    logic        lsu_arvalid = 0; logic [31:0] lsu_araddr = 0;
    logic [3:0]  lsu_arid = 0;    logic [7:0]  lsu_arlen = 0;
    logic [2:0]  lsu_arsize = 2;  logic [1:0]  lsu_arburst = 1;
    logic        lsu_arready, lsu_rvalid, lsu_rlast;
    logic [31:0] lsu_rdata;       logic [1:0]  lsu_rresp;
    logic [3:0]  lsu_rid;         logic        lsu_rready = 0;
    logic        lsu_awvalid = 0; logic [31:0] lsu_awaddr = 0;
    logic [3:0]  lsu_awid = 0;    logic [7:0]  lsu_awlen = 0;
    logic [2:0]  lsu_awsize = 2;  logic [1:0]  lsu_awburst = 1;
    logic        lsu_awready;
    logic        lsu_wvalid = 0;  logic [31:0] lsu_wdata = 0;
    logic [3:0]  lsu_wstrb = 0;   logic        lsu_wlast = 0;
    logic        lsu_wready, lsu_bvalid;
    logic [1:0]  lsu_bresp;       logic [3:0]  lsu_bid;
    logic        lsu_bready = 0;

    logic        s_awvalid;       logic [31:0] s_awaddr;
    logic [3:0]  s_awid;          logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;        logic [1:0]  s_awburst;
    logic        s_awready = 0;
    logic        s_wvalid;        logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;         logic        s_wlast;
    logic        s_wready = 0;
    logic        s_bvalid = 0;    logic [1:0]  s_bresp = 0;
    logic [3:0]  s_bid = 0;       logic        s_bready;
    logic        s_arvalid;       logic [31:0] s_araddr;
    logic [3:0]  s_arid;          logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;        logic [1:0]  s_arburst;
    logic        s_arready = 1;
    logic        s_rvalid = 0;    logic [31:0] s_rdata = 0;
    logic [1:0]  s_rresp = 0;     logic        s_rlast = 0;
    logic [3:0]  s_rid = 0;       logic        s_rready;

    ysyx_25020037_axi_arbiter #(.LSU_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .lsu_bready(lsu_bready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid), .s_rready(s_rready)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected response word and compare it with the master side.
    task automatic pop_chk(input string tag, input logic vld,
                           input logic [31:0] obs);
        chk({tag, "_valid"}, {31'd0, vld}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, sb.pop_front());
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_s_arvalid"}, {31'd0, s_arvalid}, 0);
        chk({tag, "_s_awvalid"}, {31'd0, s_awvalid}, 0);
        chk({tag, "_s_wvalid"},  {31'd0, s_wvalid},  0);
        chk({tag, "_s_rready"},  {31'd0, s_rready},  0);
        chk({tag, "_s_bready"},  {31'd0, s_bready},  0);
        chk({tag, "_s_araddr"},  s_araddr, 0);
        chk({tag, "_readies"},
            {28'd0, ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
        chk({tag, "_rsp_valids"},
            {29'd0, ifu_rvalid, lsu_rvalid, lsu_bvalid}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b0;
        cyc(); cyc();
        #1 idle_outs("reset");
        rst = 1'b1;

        // Single IFU read
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arid = 4'h2;
        ifu_rready = 1;
        #1 chk("ifu1_arvalid_T", {31'd0, s_arvalid}, 0);
        cyc();
        #1 chk("ifu1_arvalid_T1", {31'd0, s_arvalid}, 1);
        chk("ifu1_araddr", s_araddr, 32'h3000_0000);
        chk("ifu1_arid", {28'd0, s_arid}, 2);
        chk("ifu1_arready", {31'd0, ifu_arready}, 1);
        cyc();
        ifu_arvalid = 0;
        cyc(); cyc();
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1; s_rid = 4'h2;
        sb.push_back(32'hDEAD_BEEF);
        #1 pop_chk("ifu1_rdata", ifu_rvalid, ifu_rdata);
        chk("ifu1_rid", {28'd0, ifu_rid}, 2);
        chk("ifu1_lsu_rvalid", {31'd0, lsu_rvalid}, 0);
        cyc();
        #1 chk("ifu1_stray_ifu_rvalid", {31'd0, ifu_rvalid}, 0);
        chk("ifu1_stray_s_rready", {31'd0, s_rready}, 0);
        s_rvalid = 0; s_rlast = 0;

        // Simultaneous IFU and LSU reads, LSU wins
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0004;
        lsu_arvalid = 1; lsu_araddr = 32'h0F00_0000; lsu_rready = 1;
        cyc();
        #1 chk("sim_araddr_lsu", s_araddr, 32'h0F00_0000);
        chk("sim_lsu_arready", {31'd0, lsu_arready}, 1);
        chk("sim_ifu_arready0", {31'd0, ifu_arready}, 0);
        cyc();
        lsu_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'h1111_2222; s_rlast = 1;
        sb.push_back(32'h1111_2222);
        #1 pop_chk("sim_lsu_rdata", lsu_rvalid, lsu_rdata);
        chk("sim_ifu_rvalid0", {31'd0, ifu_rvalid}, 0);
        chk("sim_ifu_arready1", {31'd0, ifu_arready}, 0);
        cyc();
        s_rvalid = 0; s_rlast = 0;
        #1 chk("sim_ifu_arready_bubble", {31'd0, ifu_arready}, 0);
        cyc();
        #1 chk("sim_ifu_granted", {31'd0, ifu_arready}, 1);
        chk("sim_araddr_ifu", s_araddr, 32'h3000_0004);
        cyc();
        ifu_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rlast = 1;
        sb.push_back(32'hCAFE_F00D);
        #1 pop_chk("sim_ifu_rdata", ifu_rvalid, ifu_rdata);
        cyc();
        s_rvalid = 0; s_rlast = 0;

        // LSU write, AW and W accepted in different cycles
        lsu_awvalid = 1; lsu_awaddr = 32'hA000_0010; lsu_awid = 4'h5;
        lsu_wvalid = 1; lsu_wdata = 32'h0000_00AB; lsu_wstrb = 4'b0001;
        lsu_wlast = 1; lsu_bready = 1;
        cyc();
        s_awready = 1;
        #1 chk("wr_s_awvalid", {31'd0, s_awvalid}, 1);
        chk("wr_s_awaddr", s_awaddr, 32'hA000_0010);
        chk("wr_s_arvalid0", {31'd0, s_arvalid}, 0);
        chk("wr_lsu_awready", {31'd0, lsu_awready}, 1);
        chk("wr_lsu_wready0", {31'd0, lsu_wready}, 0);
        cyc();
        lsu_awvalid = 0; s_awready = 0;
        #1 chk("wr_s_awvalid_done", {31'd0, s_awvalid}, 0);
        chk("wr_s_wvalid_held", {31'd0, s_wvalid}, 1);
        cyc();
        s_wready = 1;
        #1 chk("wr_lsu_wready", {31'd0, lsu_wready}, 1);
        chk("wr_s_wdata", s_wdata, 32'h0000_00AB);
        chk("wr_s_wstrb", {28'd0, s_wstrb}, 1);
        cyc();
        lsu_wvalid = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h5;
        sb.push_back({26'd0, 4'h5, 2'b00});
        #1 pop_chk("wr_bid_bresp", lsu_bvalid, {26'd0, lsu_bid, lsu_bresp});
        chk("wr_s_bready", {31'd0, s_bready}, 1);
        cyc();
        #1 chk("wr_stray_lsu_bvalid", {31'd0, lsu_bvalid}, 0);
        chk("wr_stray_s_bready", {31'd0, s_bready}, 0);
        s_bvalid = 0;

        // IFU burst read, LSU request raised mid-burst
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd3;
        cyc();
        #1 chk("burst_arlen", {24'd0, s_arlen}, 3);
        cyc();
        ifu_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = 1; s_rdata = 32'h1000 + i; s_rlast = (i == 3);
            sb.push_back(32'h1000 + i);
            if (i == 1) begin
                lsu_arvalid = 1; lsu_araddr = 32'h0F00_0040; lsu_awvalid = 1;
            end
            #1 pop_chk($sformatf("burst_beat%0d", i), ifu_rvalid, ifu_rdata);
            if (i >= 1) chk($sformatf("burst_lsu_wait%0d", i),
                            {31'd0, lsu_arready}, 0);
            cyc();
        end
        s_rvalid = 0; s_rlast = 0;
        #1 chk("burst_lsu_bubble", {31'd0, lsu_arready}, 0);
        cyc();
        #1 chk("burst_lsu_granted", {31'd0, lsu_arready}, 1);
        chk("burst_lsu_addr", s_araddr, 32'h0F00_0040);
        chk("burst_rd_over_wr", {31'd0, s_awvalid}, 0);
        cyc();
        lsu_arvalid = 0; lsu_awvalid = 0;

        // Reset while RD_LSU waits for data
        rst = 0;
        cyc();
        rst = 1;
        #1 idle_outs("midreset");
        s_rvalid = 1; s_rdata = 32'h5555_AAAA; s_rlast = 1;
        #1 chk("midreset_stray_lsu_rvalid", {31'd0, lsu_rvalid}, 0);
        chk("midreset_stray_s_rready", {31'd0, s_rready}, 0);
        cyc();
        s_rvalid = 0; s_rlast = 0;
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
